// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst initiator fed by cmd/wr/rd streams.
// Define AXI_MASTER_RESP_CHECK_EN to build the sticky response/ID/RLAST error flag.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_t;

    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  last_beat;

    assign cmd_hs    = cmd_valid & cmd_ready;
    assign aw_hs     = m_axi_awvalid & m_axi_awready;
    assign w_hs      = m_axi_wvalid & m_axi_wready;
    assign b_hs      = m_axi_bvalid & m_axi_bready;
    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign r_hs      = m_axi_rvalid & m_axi_rready;
    assign last_beat = (beat_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= b_hs | (r_hs & last_beat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            beat_cnt <= '0;
        end else if (cmd_hs) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            id_q     <= cmd_id;
            beat_cnt <= cmd_len;
        end else if (w_hs | r_hs) begin
            beat_cnt <= beat_cnt - 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cmd_hs) state_next = cmd_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (aw_hs) state_next = WR_DATA;
            WR_DATA: if (w_hs && last_beat) state_next = WR_RESP;
            WR_RESP: if (b_hs) state_next = IDLE;
            RD_ADDR: if (ar_hs) state_next = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the registered state only.
    always_comb begin
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        unique case (state)
            IDLE:    cmd_ready = ~rst;
            WR_ADDR: m_axi_awvalid = 1'b1;
            WR_DATA: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = last_beat;
            end
            WR_RESP: m_axi_bready = 1'b1;
            RD_ADDR: m_axi_arvalid = 1'b1;
            RD_DATA: begin
                rd_valid     = m_axi_rvalid;
                m_axi_rready = rd_ready;
                rd_last      = last_beat;
            end
            default: ;
        endcase
    end

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign rd_data       = m_axi_rdata;

`ifdef AXI_MASTER_RESP_CHECK_EN
    logic err_b, err_r;

    assign err_b = b_hs & ((m_axi_bresp != 2'b00) | (m_axi_bid != id_q));
    // rlast must agree with our own beat count on every beat.
    assign err_r = r_hs & ((m_axi_rresp != 2'b00) | (m_axi_rid != id_q) |
                           (m_axi_rlast != last_beat));

    always_ff @(posedge clk) begin
        if (rst) error <= 1'b0;
        else if (err_b | err_r) error <= 1'b1;
    end
`else
    logic unused_resp;

    assign unused_resp = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp, m_axi_rlast};
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: randomized scoreboard bench with an in-bench AXI4 memory slave.
`timescale 1ns/1ps
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr, cmd_len, cmd_id;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        busy, done, error;
    logic [7:0]  m_axi_awid, m_axi_awaddr, m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [3:0]  m_axi_awcache;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [7:0]  m_axi_arid, m_axi_araddr, m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_arcache;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

`ifdef AXI_MASTER_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // ---------------- AXI4 memory slave ----------------
    logic [31:0] smem [64] = '{default: 32'h0};
    logic        s_wact = 1'b0;
    logic        s_ract = 1'b0;
    logic [5:0]  s_waddr, s_raddr;
    logic [7:0]  s_rcnt, s_wid;
    int          slave_rand = 0;
    logic        bresp_err_next = 1'b0;

    function automatic logic coin();
        return (slave_rand == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    endfunction

    assign m_axi_rresp = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            m_axi_awready <= 1'b0;
            m_axi_wready  <= 1'b0;
            m_axi_bvalid  <= 1'b0;
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rlast   <= 1'b0;
            s_wact        <= 1'b0;
            s_ract        <= 1'b0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                m_axi_awready <= 1'b0;
                s_wact        <= 1'b1;
                s_waddr       <= m_axi_awaddr[7:2];
                s_wid         <= m_axi_awid;
                m_axi_wready  <= coin();
            end else begin
                m_axi_awready <= !s_wact && !m_axi_bvalid && coin();
            end
            if (s_wact) begin
                if (m_axi_wvalid && m_axi_wready) begin
                    smem[s_waddr] <= merge(smem[s_waddr], m_axi_wdata, m_axi_wstrb);
                    s_waddr <= s_waddr + 6'd1;
                    if (m_axi_wlast) begin
                        s_wact       <= 1'b0;
                        m_axi_wready <= 1'b0;
                        m_axi_bvalid <= 1'b1;
                        m_axi_bid    <= s_wid;
                        m_axi_bresp  <= bresp_err_next ? 2'b10 : 2'b00;
                    end else begin
                        m_axi_wready <= coin();
                    end
                end else begin
                    m_axi_wready <= coin();
                end
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arready <= 1'b0;
                s_ract        <= 1'b1;
                s_raddr       <= m_axi_araddr[7:2];
                s_rcnt        <= m_axi_arlen;
                m_axi_rid     <= m_axi_arid;
            end else begin
                m_axi_arready <= !s_ract && coin();
            end
            if (s_ract) begin
                if (m_axi_rvalid && m_axi_rready) begin
                    if (s_rcnt == 8'd0) begin
                        m_axi_rvalid <= 1'b0;
                        s_ract       <= 1'b0;
                    end else begin
                        m_axi_rvalid <= coin();
                        m_axi_rdata  <= smem[s_raddr + 6'd1];
                        m_axi_rlast  <= (s_rcnt == 8'd1);
                        s_raddr      <= s_raddr + 6'd1;
                        s_rcnt       <= s_rcnt - 8'd1;
                    end
                end else if (!m_axi_rvalid && coin()) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= smem[s_raddr];
                    m_axi_rlast  <= (s_rcnt == 8'd0);
                end
            end
        end
    end

    // ---------------- stream drivers ----------------
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } wbeat_t;
    typedef struct packed { logic [7:0] addr; logic [7:0] len; logic [7:0] id; } axreq_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wexp_t;
    typedef struct packed { logic [31:0] data; logic last; } rexp_t;

    wbeat_t wq[$];
    axreq_t exp_aw[$];
    axreq_t exp_ar[$];
    wexp_t  exp_w[$];
    rexp_t  exp_rd[$];
    int     wmode = 0;
    int     rmode = 0;

    initial begin
        logic hs;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_strb  = '0;
        forever begin
            @(negedge clk);
            hs = wr_valid && wr_ready && !rst;
            @(posedge clk);
            #1;
            if (hs && wq.size() > 0) void'(wq.pop_front());
            if (wq.size() > 0 && (wmode == 0 || (wmode == 1 && !wr_valid) ||
                                  (wmode == 2 && $urandom_range(0, 1) == 1))) begin
                wr_valid = 1'b1;
                wr_data  = wq[0].data;
                wr_strb  = wq[0].strb;
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = !rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int     done_cnt = 0;
    int     whs_cnt  = 0;
    int     rhs_cnt  = 0;
    logic   done_pend = 1'b0;
    logic   aw_wait = 1'b0;
    logic   ar_wait = 1'b0;
    axreq_t aw_prev, ar_prev;

    initial begin
        axreq_t e;
        wexp_t  we;
        rexp_t  re;
        forever begin
            @(negedge clk);
            if (done_pend) begin
                chk("done_pulse", 64'(done), 64'(1));
                chk("done_busy_low", 64'(busy), 64'(0));
                chk("done_cmd_ready", 64'(cmd_ready), 64'(1));
            end else if (done) begin
                chk("done_spurious", 64'(done), 64'(0));
            end
            if (done) done_cnt++;
            done_pend = 1'b0;
            if (rst) begin
                aw_wait = 1'b0;
                ar_wait = 1'b0;
            end else begin
                if (aw_wait)
                    chk("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awid}),
                        64'({1'b1, aw_prev}));
                if (ar_wait)
                    chk("ar_hold", 64'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid}),
                        64'({1'b1, ar_prev}));
                aw_wait = m_axi_awvalid && !m_axi_awready;
                ar_wait = m_axi_arvalid && !m_axi_arready;
                aw_prev = '{m_axi_awaddr, m_axi_awlen, m_axi_awid};
                ar_prev = '{m_axi_araddr, m_axi_arlen, m_axi_arid};
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
                    else begin
                        e = exp_aw.pop_front();
                        chk("aw_fields", 64'({m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize,
                            m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot}),
                            64'({e.addr, e.len, e.id, 3'd2, 2'd1, 1'b0, 4'd3, 3'd0}));
                    end
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
                    else begin
                        e = exp_ar.pop_front();
                        chk("ar_fields", 64'({m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize,
                            m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}),
                            64'({e.addr, e.len, e.id, 3'd2, 2'd1, 1'b0, 4'd3, 3'd0}));
                    end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    whs_cnt++;
                    if (exp_w.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
                    else begin
                        we = exp_w.pop_front();
                        chk("w_beat", 64'({m_axi_wdata, m_axi_wstrb, m_axi_wlast}), 64'(we));
                    end
                end
                if (m_axi_bvalid && m_axi_bready) done_pend = 1'b1;
                if (rd_valid && rd_ready) begin
                    rhs_cnt++;
                    if (exp_rd.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
                    else begin
                        re = exp_rd.pop_front();
                        chk("rd_beat", 64'({rd_data, rd_last}), 64'(re));
                        done_pend = re.last;
                    end
                end
            end
        end
    end

    // ---------------- reference model and stimulus ----------------
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    logic [31:0] beat_d [256];
    logic [3:0]  beat_s [256];

    task automatic flush();
        exp_aw.delete();
        exp_ar.delete();
        exp_w.delete();
        exp_rd.delete();
        wq.delete();
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] len,
                         input logic [7:0] id);
        logic [5:0] idx;
        int t;
        if (wr) begin
            exp_aw.push_back('{addr, len, id});
            for (int i = 0; i <= int'(len); i++) begin
                idx = addr[7:2] + 6'(i);
                exp_w.push_back('{beat_d[i], beat_s[i], (i == int'(len))});
                wq.push_back('{beat_d[i], beat_s[i]});
                ref_mem[idx] = merge(ref_mem[idx], beat_d[i], beat_s[i]);
            end
        end else begin
            exp_ar.push_back('{addr, len, id});
            for (int i = 0; i <= int'(len); i++) begin
                idx = addr[7:2] + 6'(i);
                exp_rd.push_back('{ref_mem[idx], (i == int'(len))});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready || t > 200) break;
            t++;
        end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("axvalid_latency", 64'(wr ? m_axi_awvalid : m_axi_arvalid), 64'(1));
        chk("busy_active", 64'(busy), 64'(1));
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] len,
                           input logic [7:0] id);
        int start;
        int t;
        start = done_cnt;
        issue(wr, addr, len, id);
        t = 0;
        while (done_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == start) begin
            chk("done_timeout", 64'(done_cnt), 64'(start + 1));
            reset_pulse();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, start, t, widx;
        logic [7:0] len, addr;
        logic wr;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        cmd_id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_outputs", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready,
            m_axi_rready, wr_ready, rd_valid, done, busy, error}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        // directed burst write then read back, slave always ready
        for (int i = 0; i < 4; i++) begin
            beat_d[i] = 32'hA0 + 32'(i);
            beat_s[i] = 4'hF;
        end
        run_cmd(1'b1, 8'h10, 8'd3, 8'h5A);
        for (int i = 0; i < 4; i++) chk("mem_burst_write", 64'(smem[4+i]), 64'(32'hA0 + i));
        run_cmd(1'b0, 8'h10, 8'd3, 8'h21);
        chk("error_after_read", 64'(error), 64'(0));

        // single beat with partial strobes
        beat_d[0] = 32'h1111_1111;
        beat_s[0] = 4'hF;
        run_cmd(1'b1, 8'h00, 8'd0, 8'h01);
        beat_d[0] = 32'hDEAD_BEEF;
        beat_s[0] = 4'h3;
        run_cmd(1'b1, 8'h00, 8'd0, 8'h02);
        chk("mem_partial_strb", 64'(smem[0]), 64'(32'h1111_BEEF));

        // backpressure on both streams plus a randomly stalling slave
        wmode = 1;
        rmode = 1;
        slave_rand = 1;
        for (int i = 0; i < 8; i++) begin
            beat_d[i] = $urandom;
            beat_s[i] = 4'hF;
        end
        w0 = whs_cnt;
        run_cmd(1'b1, 8'h40, 8'd7, 8'h33);
        chk("bp_w_beats", 64'(whs_cnt - w0), 64'(8));
        r0 = rhs_cnt;
        run_cmd(1'b0, 8'h40, 8'd7, 8'h34);
        chk("bp_r_beats", 64'(rhs_cnt - r0), 64'(8));

        // reset mid-burst; rewriting current contents keeps memory deterministic
        wmode = 0;
        rmode = 0;
        slave_rand = 0;
        for (int i = 0; i < 8; i++) begin
            beat_d[i] = ref_mem[16+i];
            beat_s[i] = 4'hF;
        end
        w0 = whs_cnt;
        issue(1'b1, 8'h40, 8'd7, 8'h44);
        t = 0;
        while (whs_cnt - w0 < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached_beat2", 64'(whs_cnt - w0 >= 2), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #2;
        flush();
        @(negedge clk);
        chk("rst_mid_outputs", 64'({m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready,
            m_axi_rready, wr_ready, rd_valid, busy}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd_ready_after", 64'(cmd_ready), 64'(1));
        start = done_cnt;
        run_cmd(1'b0, 8'h44, 8'd0, 8'h45);
        chk("rst_mid_read_done", 64'(done_cnt - start), 64'(1));

        // slave error response
        bresp_err_next = 1'b1;
        beat_d[0] = 32'hCAFE_0001;
        beat_d[1] = 32'hCAFE_0002;
        beat_s[0] = 4'hF;
        beat_s[1] = 4'hF;
        run_cmd(1'b1, 8'h80, 8'd1, 8'h66);
        bresp_err_next = 1'b0;
        chk("error_after_bresp", 64'(error), 64'(EXP_ERR));
        run_cmd(1'b0, 8'h80, 8'd1, 8'h67);
        chk("error_sticky", 64'(error), 64'(EXP_ERR));

        // randomized traffic
        for (int n = 0; n < 24; n++) begin
            wmode = $urandom_range(0, 2);
            rmode = $urandom_range(0, 2);
            slave_rand = $urandom_range(0, 1);
            len = 8'($urandom_range(0, 15));
            widx = $urandom_range(0, 63 - int'(len));
            addr = 8'(widx * 4);
            wr = 1'($urandom_range(0, 1));
            for (int i = 0; i <= int'(len); i++) begin
                beat_d[i] = $urandom;
                beat_s[i] = 4'($urandom_range(1, 15));
            end
            run_cmd(wr, addr, len, 8'($urandom_range(0, 255)));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk("mem_final", 64'(smem[i]), 64'(ref_mem[i]));
        chk("error_final", 64'(error), 64'(EXP_ERR));
        chk("queues_drained", 64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size()),
            64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

AXI4 burst initiator that converts simple command, write-stream and read-stream interfaces into single-ID AXI4 transactions. It is the master-side counterpart for the block-RAM AXI4 slave and drives its `s_axi_*` ports in simulation and co-simulation. One transaction is outstanding at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width in bits.
- ADDR_WIDTH, 8, AXI byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, byte strobes per beat.
- ID_WIDTH, 8, AXI ID width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address, driven unchanged onto AxADDR.
- cmd_len  in  8  beats minus 1 (0..255).
- cmd_id  in  ID_WIDTH  driven onto AxID.
- wr_data / wr_strb / wr_valid / wr_ready  in / in / in / out  DATA_WIDTH / STRB_WIDTH / 1 / 1  write-beat stream.
- rd_data / rd_last / rd_valid / rd_ready  out / out / out / in  DATA_WIDTH / 1 / 1 / 1  read-beat stream.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a transaction completes.
- error  out  1  sticky response error (see Configuration).
- m_axi_aw* (id, addr, len, size, burst, lock, cache, prot, valid, ready), m_axi_w* (data, strb, last, valid, ready), m_axi_b* (id, resp, valid, ready), m_axi_ar* (same as aw*), m_axi_r* (id, data, resp, last, valid, ready): standard AXI4 master ports at the widths above.

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready=1.
  - On cmd handshake, latch addr, len, id and load beat_cnt=cmd_len.
  - Go to WR_ADDR if cmd_write, else RD_ADDR.
- WR_ADDR / RD_ADDR: AxVALID=1 with the latched fields; AxVALID is held with stable fields until AxREADY.
  - Constant fields: AxSIZE=log2(STRB_WIDTH), AxBURST=2'b01 (INCR), AxLOCK=0, AxCACHE=4'b0011, AxPROT=0.
  - On handshake, go to WR_DATA or RD_DATA.
- WR_DATA: combinational pass-through, gated by state.
  - m_axi_wvalid = wr_valid; wr_ready = m_axi_wready; wdata and wstrb pass through.
  - m_axi_wlast = (beat_cnt==0).
  - beat_cnt decrements on each W handshake. The handshake with wlast moves the FSM to WR_RESP.
- WR_RESP: m_axi_bready=1. On B handshake, pulse done and return to IDLE.
- RD_DATA: pass-through.
  - rd_valid = m_axi_rvalid; m_axi_rready = rd_ready; rd_data = rdata; rd_last = (beat_cnt==0).
  - On each R handshake, beat_cnt decrements. The handshake at beat_cnt==0 pulses done and returns to IDLE, whatever the value of rlast.
- Outside their state, all valid/ready outputs are 0 (wr_ready, rd_valid, m_axi_bready, m_axi_rready included).
- AW is always issued before W; no W beat is presented before the AW handshake.
- The address counter is not used; the slave generates burst addresses. 4 KB crossing is not checked (ADDR_WIDTH ≤ 12).

## Timing
- Reset values:
  - FSM = IDLE.
  - awvalid, arvalid, wvalid, bready, rready, wr_ready, rd_valid, done, busy, error = 0.
  - cmd_ready = 0 while rst=1.
- Reset mid-burst: the burst is abandoned immediately and all valids drop the next cycle. The bench must reset the slave together with this block.
- Latency: cmd handshake at cycle N → AxVALID=1 at N+1 (registered).
- Write completion: B handshake at cycle M → done=1 at M+1, cmd_ready=1 at M+1.
- Read completion: final R handshake at M → done=1 and cmd_ready=1 at M+1.
- Back-to-back: the next command can be accepted in the same cycle that done is high. Minimum gap between AxVALID of consecutive transactions is 2 cycles.
- Pass-through paths add zero latency. A full-throughput burst of len+1 beats takes len+1 cycles.
- cmd_len=0: a single beat; wlast (or rd_last) is asserted on the first beat.
- busy = (state != IDLE), registered with the state.

## Configuration
- AXI_MASTER_RESP_CHECK_EN defined:
  - error is set by any BRESP≠2'b00, any RRESP≠2'b00, rlast=1 on a non-final beat, or rlast=0 on the final beat.
  - error is also set by BID or RID ≠ latched id.
  - error is sticky until rst.
- Not defined: error is tied to 0, and no response or ID checking logic is compiled in.

## Test plan
- Write addr=0x10, len=3, data 0xA0..0xA3, strb=0xF, slave always ready → AW fields 0x10/3/size 2/burst 1; wlast on 4th beat; done 1 cycle after B handshake; slave mem[4..7]=0xA0..0xA3.
- Read addr=0x10, len=3 after the previous write → rd_data 0xA0..0xA3 in order, rd_last on 4th beat, done next cycle, error=0.
- Single-beat write addr=0x00, len=0, strb=0x3, data 0xDEADBEEF over 0x11111111 → mem[0]=0x1111BEEF; wlast on the only beat.
- Backpressure: rd_ready toggling 1010… and wr_valid toggling during len=7 bursts → no beat lost or duplicated; 8 handshakes each; AxVALID stays stable until ready.
- Assert rst during beat 2 of a len=7 write → all valids 0 next cycle, busy=0, cmd_ready=1 after rst drops; a new len=0 read completes normally.
- With AXI_MASTER_RESP_CHECK_EN defined: slave returns BRESP=2'b10 → error=1 and stays 1 across a later clean read. Without the macro: error=0 throughout.
